i2s_rx_ctrl: RTL
================

Name: i2s_rx_ctrl

Overview:
- Controller that sequences the I2S receiver: drives its enable, discards warm-up samples after start, and pairs tagged left/right words into stereo frames.
- Buffers frames in a small FIFO behind a valid/ready consumer interface.
- Reports overflow, channel misalignment and sample-stream timeout through sticky flags.
- Sits between i2s_receiver and the audio DSP/DMA consumer.

Parameters:
- DATA_W, 24, width of one channel word.
- DISCARD_SAMPLES, 64, words dropped after start, counted as L and R individually; range 0..255.
- FIFO_DEPTH, 4, stereo frames buffered; power of two, ≥2.
- TIMEOUT_CYCLES, 1024, maximum clk_i cycles between rx_new_sample_i pulses while receiving.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset
- start_i  in  1  pulse; begin capture (honoured in IDLE only)
- stop_i  in  1  pulse; end capture gracefully
- rx_enable_o  out  1  enable to i2s_receiver
- rx_sample_i  in  DATA_W  word from receiver
- rx_new_sample_i  in  1  one-cycle strobe, rx_sample_i valid
- rx_lrclk_i  in  1  receiver lrclk at strobe; 1 = completed word is LEFT, 0 = RIGHT
- frame_left_o  out  DATA_W  FIFO head, left word
- frame_right_o  out  DATA_W  FIFO head, right word
- frame_valid_o  out  1  FIFO non-empty
- frame_ready_i  in  1  consumer accepts head when valid&ready
- busy_o  out  1  state != IDLE
- overflow_o  out  1  sticky: complete frame dropped, FIFO full
- misalign_o  out  1  sticky: channel order violation
- timeout_o  out  1  sticky: sample gap exceeded
- err_clr_i  in  1  clears all three sticky flags

Behaviour:
- Reset is asynchronous and active-low on rst_ni; clock is clk_i.
- Reset values: state IDLE, rx_enable_o 0, FIFO empty, frame_valid_o 0, frame_left_o/frame_right_o 0, busy_o 0, all sticky flags 0, no held left word.
- FSM states: IDLE, WARMUP, RUN, DRAIN.
- IDLE:
  - rx_enable_o = 0.
  - start_i → WARMUP, registered so rx_enable_o = 1 the next cycle.
  - Clears the discard counter, gap counter and held-left register.
  - stop_i is ignored.
- WARMUP:
  - Each strobe increments the discard counter; nothing is pushed.
  - When DISCARD_SAMPLES strobes have been seen → RUN, expecting LEFT.
  - DISCARD_SAMPLES = 0 → WARMUP is left on the first cycle.
  - stop_i → IDLE.
- RUN, expecting LEFT:
  - A LEFT strobe latches the word as held-left; now expecting RIGHT.
  - A RIGHT strobe drops the word, sets misalign_o and stays expecting LEFT.
- RUN, expecting RIGHT:
  - A RIGHT strobe forms the frame {held-left, word}; push is attempted on that clock edge.
  - A LEFT strobe replaces held-left and sets misalign_o.
- Push rule:
  - A push is accepted iff FIFO count < FIFO_DEPTH at the start of the cycle. A pop in the same cycle does not free space for it.
  - A rejected push discards the frame and sets overflow_o.
- stop_i in RUN:
  - No held-left → IDLE.
  - Held-left pending → DRAIN.
- DRAIN: waits for the RIGHT strobe, pushes the frame (push rule applies), then → IDLE. A LEFT strobe in DRAIN → IDLE with held-left discarded and misalign_o set.
- Timeout:
  - The gap counter resets on every strobe and counts in WARMUP/RUN/DRAIN.
  - Reaching TIMEOUT_CYCLES sets timeout_o and forces IDLE; rx_enable_o drops the next cycle and held-left is discarded.
- FIFO contents survive IDLE transitions and stay drainable; only reset empties the FIFO.
- Latency: RIGHT strobe in cycle N with FIFO empty → frame_valid_o = 1 in cycle N+1. Head outputs come from registered FIFO storage; no combinational path from rx_* to frame_*.
- Pop: occurs on valid & ready. Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- Sticky flags:
  - err_clr_i clears them.
  - A set event in the same cycle as err_clr_i wins (flag = 1).
  - Flags are not cleared by start_i.
- Strobes in IDLE are ignored.

Decomposition:
- Package i2s_pkg:
  - DATA_W default.
  - Typedef rx_ctrl_state_t {IDLE, WARMUP, RUN, DRAIN}.
  - Packed struct stereo_frame_t {left, right}.
- Sub-module stereo_frame_fifo:
  - Parameterised on depth.
  - Push/pop, count, full/empty.
  - Registered storage of stereo_frame_t.

Test Plan:
- Warm-up discard: DISCARD_SAMPLES = 4; start, then strobes L1 R1 L2 R2 L3 R3 → exactly one frame {L3,R3}, valid 1 cycle after the R3 strobe.
- Overflow: DEPTH = 4, ready = 0, 5 pairs {i, i+100} → count 4, overflow_o = 1; drain yields {1,101}..{4,104} in order.
- Misalignment: in RUN, strobes R, L5, L6, R7 → misalign_o = 1, single frame {L6,R7}. err_clr_i → 0.
- Graceful stop: stop_i after L8, then R9 → frame {L8,R9} pushed, then IDLE, rx_enable_o = 0. stop_i with no held-left → IDLE next cycle.
- Timeout: TIMEOUT_CYCLES = 1024; in RUN, no strobe for 1024 cycles → timeout_o = 1, IDLE, rx_enable_o = 0, held-left discarded. Next start re-enters WARMUP.
- Async reset mid-RUN with 3 frames queued → all outputs at reset values immediately; FIFO empty after release.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types for the I2S receive path: controller states and the stereo frame
// that travels from the channel pairing logic through the frame FIFO.
package i2s_pkg;

  localparam int I2S_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN,
    DRAIN
  } rx_ctrl_state_t;

  typedef struct packed {
    logic [I2S_DATA_W-1:0] left;
    logic [I2S_DATA_W-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/stereo_frame_fifo.sv
// Small register-based FIFO of stereo frames; head is read straight from storage.
// A push is refused while full even if a pop happens in the same cycle.
module stereo_frame_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  stereo_frame_t data_i,
  input  logic          pop_i,
  output stereo_frame_t head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  stereo_frame_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage is reset too so the head outputs read as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// Sequences the I2S receiver: warm-up discard, left/right pairing into stereo
// frames, graceful stop, sample-gap timeout and sticky error reporting.
module i2s_rx_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_W          = I2S_DATA_W,
  parameter int DISCARD_SAMPLES = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              rx_enable_o,
  input  logic [DATA_W-1:0] rx_sample_i,
  input  logic              rx_new_sample_i,
  input  logic              rx_lrclk_i,
  output logic [DATA_W-1:0] frame_left_o,
  output logic [DATA_W-1:0] frame_right_o,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              misalign_o,
  output logic              timeout_o,
  input  logic              err_clr_i
);

  localparam int               GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]       DISC_LAST = (DISCARD_SAMPLES == 0) ? 8'd0 : 8'(DISCARD_SAMPLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

  rx_ctrl_state_t    state_q;
  logic [7:0]        disc_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_d;
  logic [DATA_W-1:0] held_q;
  logic              held_vld_q;
  logic              held_vld_d;
  logic              rx_enable_q;
  logic              overflow_q;
  logic              misalign_q;
  logic              timeout_q;

  logic              frame_push;
  logic              timeout_hit;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  stereo_frame_t     push_frame;
  stereo_frame_t     head;

  // held_vld_q doubles as "expecting RIGHT"; any strobe sets it to its own channel.
  assign held_vld_d  = rx_new_sample_i ? rx_lrclk_i : held_vld_q;
  assign gap_cnt_d   = rx_new_sample_i ? '0 : gap_cnt_q + GAP_W'(1);
  assign timeout_hit = (state_q != IDLE) && !rx_new_sample_i && (gap_cnt_q == GAP_LAST);
  assign frame_push  = rx_new_sample_i && !rx_lrclk_i &&
                       (((state_q == RUN) && held_vld_q) || (state_q == DRAIN));
  assign push_frame  = '{left: held_q, right: rx_sample_i};
  assign fifo_pop    = frame_valid_o && frame_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      disc_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      held_vld_q  <= 1'b0;
      rx_enable_q <= 1'b0;
      overflow_q  <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // Clear first so that a set event later in this block wins.
      if (err_clr_i) begin
        overflow_q <= 1'b0;
        misalign_q <= 1'b0;
        timeout_q  <= 1'b0;
      end
      if (frame_push && fifo_full) begin
        overflow_q <= 1'b1;
      end
      if (state_q == IDLE) begin
        disc_cnt_q <= '0;
        gap_cnt_q  <= '0;
        held_vld_q <= 1'b0;
      end else begin
        gap_cnt_q <= gap_cnt_d;
      end

      if (timeout_hit) begin
        timeout_q   <= 1'b1;
        state_q     <= IDLE;
        rx_enable_q <= 1'b0;
        held_vld_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q     <= WARMUP;
              rx_enable_q <= 1'b1;
            end
          end
          WARMUP: begin
            if (stop_i) begin
              state_q     <= IDLE;
              rx_enable_q <= 1'b0;
            end else if (DISCARD_SAMPLES == 0) begin
              state_q <= RUN;
            end else if (rx_new_sample_i) begin
              disc_cnt_q <= disc_cnt_q + 8'd1;
              if (disc_cnt_q == DISC_LAST) begin
                state_q <= RUN;
              end
            end
          end
          RUN: begin
            if (rx_new_sample_i) begin
              held_vld_q <= rx_lrclk_i;
              if (rx_lrclk_i == held_vld_q) begin
                misalign_q <= 1'b1;
              end
            end
            if (stop_i) begin
              state_q     <= held_vld_d ? DRAIN : IDLE;
              rx_enable_q <= held_vld_d;
            end
          end
          DRAIN: begin
            if (rx_new_sample_i) begin
              state_q     <= IDLE;
              rx_enable_q <= 1'b0;
              held_vld_q  <= 1'b0;
              if (rx_lrclk_i) begin
                misalign_q <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  // Left word capture; its validity is tracked by held_vld_q.
  always_ff @(posedge clk_i) begin
    if (rx_new_sample_i && rx_lrclk_i && (state_q == RUN)) begin
      held_q <= rx_sample_i;
    end
  end

  stereo_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (frame_push),
    .data_i  (push_frame),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_enable_o   = rx_enable_q;
  assign busy_o        = (state_q != IDLE);
  assign frame_valid_o = !fifo_empty;
  assign frame_left_o  = head.left;
  assign frame_right_o = head.right;
  assign overflow_o    = overflow_q;
  assign misalign_o    = misalign_q;
  assign timeout_o     = timeout_q;

endmodule
